// File: rtl/cache_controller_if.sv
// Bundle between the MEM-stage control unit, the data-cache controller and main memory.
// The controller takes the slave view; the requester/memory model takes the master view.
interface cache_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              enable;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              mem_ready;
    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ack;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    modport master (
        output enable, mem_read, mem_write, address, write_data, ram_rdata, ram_ack,
        input  read_data, mem_ready, ram_req, ram_we, ram_addr, ram_wdata, hit_count, miss_count
    );

    modport slave (
        input  enable, mem_read, mem_write, address, write_data, ram_rdata, ram_ack,
        output read_data, mem_ready, ram_req, ram_we, ram_addr, ram_wdata, hit_count, miss_count
    );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// It uses a four-phase enable/mem_ready handshake toward the MEM stage and keeps saturating hit/miss counters.
module cache_controller #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int NUM_LINES = 64,
    parameter int CNT_W     = 16
) (
    input logic   clk,
    input logic   rst_n,
    cache_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WTHRU, DONE} state_e;

    state_e              state_r, state_s;
    logic [ADDR_W-3:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                write_op_r, read_op_r;
    logic [NUM_LINES-1:0] valid_r;
    logic [TAG_W-1:0]    tag_mem [NUM_LINES];
    logic [DATA_W-1:0]   data_mem [NUM_LINES];

    logic [DATA_W-1:0]   read_data_r, rdata_s;
    logic                mem_ready_r, ready_s;
    logic                ram_req_r, req_s;
    logic                ram_we_r, we_s;
    logic [ADDR_W-1:0]   ram_addr_r, raddr_s;
    logic [DATA_W-1:0]   ram_wdata_r, rwdata_s;
    logic [CNT_W-1:0]    hit_cnt_r, hit_cnt_s;
    logic [CNT_W-1:0]    miss_cnt_r, miss_cnt_s;
    logic                line_wr_s, fill_s;

    logic [IDX_W-1:0]    idx_s;
    logic [TAG_W-1:0]    tag_s;
    logic                lookup_hit_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign idx_s        = addr_r[IDX_W-1:0];
    assign tag_s        = addr_r[ADDR_W-3 -: TAG_W];
    assign lookup_hit_s = valid_r[idx_s] && (tag_mem[idx_s] == tag_s);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (bus.enable) state_s = LOOKUP; else state_s = IDLE;
            LOOKUP: begin
                if (write_op_r)                    state_s = WTHRU;
                else if (read_op_r && !lookup_hit_s) state_s = FILL;
                else                               state_s = DONE;
            end
            FILL:    if (bus.ram_ack) state_s = DONE; else state_s = FILL;
            WTHRU:   if (bus.ram_ack) state_s = DONE; else state_s = WTHRU;
            DONE:    if (!bus.enable) state_s = IDLE; else state_s = DONE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs plus array write strobes
    always_comb begin
        rdata_s    = read_data_r;
        ready_s    = mem_ready_r;
        req_s      = ram_req_r;
        we_s       = ram_we_r;
        raddr_s    = ram_addr_r;
        rwdata_s   = ram_wdata_r;
        hit_cnt_s  = hit_cnt_r;
        miss_cnt_s = miss_cnt_r;
        line_wr_s  = 1'b0;
        fill_s     = 1'b0;
        case (state_r)
            LOOKUP: begin
                if (write_op_r) begin
                    req_s    = 1'b1;
                    we_s     = 1'b1;
                    raddr_s  = {addr_r, 2'b00};
                    rwdata_s = wdata_r;
                    if (lookup_hit_s) begin
                        line_wr_s = 1'b1;
                        hit_cnt_s = sat_inc(hit_cnt_r);
                    end else begin
                        miss_cnt_s = sat_inc(miss_cnt_r);
                    end
                end else if (read_op_r) begin
                    if (lookup_hit_s) begin
                        rdata_s   = data_mem[idx_s];
                        hit_cnt_s = sat_inc(hit_cnt_r);
                        ready_s   = 1'b1;
                    end else begin
                        miss_cnt_s = sat_inc(miss_cnt_r);
                        req_s      = 1'b1;
                        we_s       = 1'b0;
                        raddr_s    = {addr_r, 2'b00};
                    end
                end else begin
                    ready_s = 1'b1;
                end
            end
            FILL: begin
                if (bus.ram_ack) begin
                    fill_s  = 1'b1;
                    rdata_s = bus.ram_rdata;
                    req_s   = 1'b0;
                    ready_s = 1'b1;
                end else begin
                    req_s = 1'b1;
                end
            end
            WTHRU: begin
                if (bus.ram_ack) begin
                    req_s   = 1'b0;
                    we_s    = 1'b0;
                    ready_s = 1'b1;
                end else begin
                    req_s = 1'b1;
                end
            end
            DONE: begin
                if (!bus.enable) ready_s = 1'b0;
                else             ready_s = 1'b1;
            end
            default: ;
        endcase
    end

    // Output and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_r <= {DATA_W{1'b0}};
            mem_ready_r <= 1'b0;
            ram_req_r   <= 1'b0;
            ram_we_r    <= 1'b0;
            ram_addr_r  <= {ADDR_W{1'b0}};
            ram_wdata_r <= {DATA_W{1'b0}};
            hit_cnt_r   <= {CNT_W{1'b0}};
            miss_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            read_data_r <= rdata_s;
            mem_ready_r <= ready_s;
            ram_req_r   <= req_s;
            ram_we_r    <= we_s;
            ram_addr_r  <= raddr_s;
            ram_wdata_r <= rwdata_s;
            hit_cnt_r   <= hit_cnt_s;
            miss_cnt_r  <= miss_cnt_s;
        end
    end

    // Request capture: only the accepting edge samples the MEM-stage inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r     <= {(ADDR_W-2){1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            write_op_r <= 1'b0;
            read_op_r  <= 1'b0;
        end else if (state_r == IDLE && bus.enable) begin
            addr_r     <= bus.address[ADDR_W-1:2];
            wdata_r    <= bus.write_data;
            write_op_r <= bus.mem_write;
            read_op_r  <= bus.mem_read & ~bus.mem_write;
        end
    end

    // Valid bits; strobes are inert in reset because the state is forced to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      valid_r <= {NUM_LINES{1'b0}};
        else if (fill_s) valid_r[idx_s] <= 1'b1;
    end

    // Tag/data arrays, deliberately not reset
    always_ff @(posedge clk) begin
        if (line_wr_s) begin
            data_mem[idx_s] <= wdata_r;
        end else if (fill_s) begin
            data_mem[idx_s] <= bus.ram_rdata;
            tag_mem[idx_s]  <= tag_s;
        end
    end

    assign bus.read_data  = read_data_r;
    assign bus.mem_ready  = mem_ready_r;
    assign bus.ram_req    = ram_req_r;
    assign bus.ram_we     = ram_we_r;
    assign bus.ram_addr   = ram_addr_r;
    assign bus.ram_wdata  = ram_wdata_r;
    assign bus.hit_count  = hit_cnt_r;
    assign bus.miss_count = miss_cnt_r;
endmodule
